app_state_controller: RTL and testbench
=======================================

# app_state_controller

Top-level mode sequencer for the board's menu-driven application set: it owns the menu cursor, launches one of `NUM_APPS` applications, tracks each application's end and optional game-over page, and returns to the menu on button, abort or idle timeout. It sits between the single-pulse button debouncers (1 kHz domain) and the per-application display/logic blocks. Each application is gated by a one-hot run enable and restarted by a one-cycle start pulse.

## Interface
- `NUM_APPS`, 4: number of applications, 2..8.
- `IDX_W`, 3: width of the application index; must satisfy 2^IDX_W >= `NUM_APPS`.
- `OVER_MASK`, 4'b0001: bit i=1 means app i shows a game-over page after ending; 0 means it returns directly to the menu.
- `ABORT_MASK`, 4'b1111: bit i=1 means btnU aborts app i to the menu.
- `IDLE_TIMEOUT`, 10000: cycles without any button before the game-over page auto-returns to the menu; 0 disables.

Ports:
- `clk` in 1: 1 kHz clock, same domain as the single-pulse buttons.
- `reset` in 1: asynchronous, active-high.
- `btnC`, `btnL`, `btnR`, `btnU`, `btnD` in 1 each: single-cycle button pulses.
- `app_ended` in `NUM_APPS`: per-app end flag, level or pulse.
- `mode` out 2: 2'b00 MENU, 2'b01 RUN, 2'b10 OVER. 2'b11 is never driven.
- `app_sel` out `IDX_W`: cursor position in MENU; active app in RUN and OVER.
- `app_run` out `NUM_APPS`: one-hot, bit `app_sel` high only in RUN.
- `app_start` out 1: high for exactly the first cycle of RUN.

## Operation
- All outputs are registered. Reset value: `mode`=MENU, `app_sel`=0, `app_run`=0, `app_start`=0, idle counter=0.
- **MENU**
  - btnR: `app_sel`+1, wrapping `NUM_APPS`-1 → 0.
  - btnL: `app_sel`-1, wrapping 0 → `NUM_APPS`-1.
  - btnL and btnR together: no move.
  - btnC: go to RUN with the current `app_sel`. btnC beats btnL/btnR in the same cycle; the cursor does not move.
  - btnU and btnD: ignored.
- **RUN**
  - Only `app_ended[app_sel]` is considered; other bits are ignored.
  - On end: go to OVER if `OVER_MASK[app_sel]`, else go to MENU.
  - btnU with `ABORT_MASK[app_sel]`=1: go to MENU.
  - End and abort in the same cycle: end wins.
  - btnC, btnL, btnR and btnD are ignored.
- **OVER**
  - btnC: go to MENU.
  - Idle timeout: go to MENU.
  - Other buttons only clear the idle counter.
- On return to MENU, `app_sel` keeps the last app, so the cursor stays on it.
- **Idle counter**, width clog2(`IDLE_TIMEOUT`+1):
  - Cleared on every mode change and on any button pulse.
  - Otherwise increments while in OVER; held at 0 in MENU and RUN.
  - When a cycle has counter == `IDLE_TIMEOUT`-1 and no button, the next edge goes to MENU.
- `app_start` is set on the edge entering RUN and cleared on the following edge.
- Reset asserted mid-RUN or mid-OVER forces MENU asynchronously. `app_run` drops immediately, with no `app_start`.

## Timing
- Every transition takes one edge: an input sampled high at edge N changes `mode`, `app_sel`, `app_run` and `app_start` after edge N.
- MENU→RUN: `app_run` and `app_start` rise on the same edge. `app_start` falls one edge later.
- RUN→OVER/MENU: `app_run` falls on the same edge as the `mode` change.
- Timeout: `mode` reads MENU exactly `IDLE_TIMEOUT` cycles after entering OVER, given no button pulses.
- A level-held `app_ended` has no effect outside RUN, and no effect in RUN until the app is running. Re-entering RUN while `app_ended` is still high ends it on the next edge; apps must clear the flag on `app_start`.
- Reset release: the first edge evaluates MENU inputs normally.

## Test plan
Configuration for all scenarios: `NUM_APPS`=4, `OVER_MASK`=4'b0101, `ABORT_MASK`=4'b1110, `IDLE_TIMEOUT`=5.

1. Cursor wrap. From reset, btnL → `app_sel`=3; btnR ×2 → `app_sel`=1. btnL and btnR in the same cycle → `app_sel` stays 1.
2. Launch and game-over page. btnC at `app_sel`=2 → `mode`=01, `app_run`=4'b0100, `app_start` high for 1 cycle. `app_ended`=4'b0100 → `mode`=10, `app_run`=0. btnC → `mode`=00 with `app_sel`=2.
3. Direct return and ignored bits. Run app 1. `app_ended`=4'b1101 → no change. `app_ended`=4'b0010 → `mode`=00 (`OVER_MASK[1]`=0).
4. Abort. Run app 0 and pulse btnU → stays in RUN (abort disabled). Run app 3 and pulse btnU → MENU. Pulse btnU and `app_ended[3]` in the same cycle → `mode`=00 via the end path.
5. Idle timeout. Enter OVER on app 0 with no buttons → `mode`=00 after exactly 5 cycles. Repeat with btnL on cycle 3 → return occurs 5 cycles after that pulse.
6. Async reset. Assert `reset` mid-RUN between edges → `mode`=00, `app_run`=0, `app_sel`=0 immediately. Deassert, then btnC → RUN on app 0.

Source files
------------

// File: rtl/app_state_controller.sv
// app_state_controller: menu cursor, application launch, game-over page and idle return sequencer.
// Buttons are single-cycle pulses in the same clock domain; every output is registered.
module app_state_controller #(
   parameter int                  NUM_APPS     = 4,
   parameter int                  IDX_W        = 3,
   parameter logic [NUM_APPS-1:0] OVER_MASK    = 4'b0001,
   parameter logic [NUM_APPS-1:0] ABORT_MASK   = 4'b1111,
   parameter int                  IDLE_TIMEOUT = 10000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btnC,
   input  logic                btnL,
   input  logic                btnR,
   input  logic                btnU,
   input  logic                btnD,
   input  logic [NUM_APPS-1:0] app_ended,
   output logic [1:0]          mode,
   output logic [IDX_W-1:0]    app_sel,
   output logic [NUM_APPS-1:0] app_run,
   output logic                app_start
);
   localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_APP = IDX_W'(NUM_APPS - 1);

   typedef enum logic [1:0] {MENU = 2'b00, RUN = 2'b01, OVER = 2'b10} mode_t;

   mode_t               r_mode;
   logic [IDX_W-1:0]    r_sel;
   logic [NUM_APPS-1:0] r_run;
   logic                r_start;
   logic [CNT_W-1:0]    r_idle;

   logic w_btn, w_end, w_over, w_abort, w_timeout;

   // r_run is one-hot on the active app in RUN, so masking with it selects that app's bits
   assign w_btn     = btnC | btnL | btnR | btnU | btnD;
   assign w_end     = |(app_ended & r_run);
   assign w_over    = |(OVER_MASK & r_run);
   assign w_abort   = btnU & (|(ABORT_MASK & r_run));
   assign w_timeout = (IDLE_TIMEOUT != 0) && !w_btn && (r_idle == IDLE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode  <= MENU;
         r_sel   <= '0;
         r_run   <= '0;
         r_start <= 1'b0;
         r_idle  <= '0;
      end else begin
         r_start <= 1'b0;
         r_idle  <= '0;
         case (r_mode)
            MENU: begin
               if (btnC) begin
                  r_mode  <= RUN;
                  r_run   <= NUM_APPS'(1) << r_sel;
                  r_start <= 1'b1;
               end else if (btnR && !btnL) begin
                  r_sel <= (r_sel == LAST_APP) ? '0 : r_sel + 1'b1;
               end else if (btnL && !btnR) begin
                  r_sel <= (r_sel == '0) ? LAST_APP : r_sel - 1'b1;
               end
            end
            RUN: begin
               if (w_end || w_abort) begin
                  r_mode <= (w_end && w_over) ? OVER : MENU;
                  r_run  <= '0;
               end
            end
            OVER: begin
               if (btnC || w_timeout) r_mode <= MENU;
               else r_idle <= w_btn ? '0 : r_idle + 1'b1;
            end
            default: begin
               r_mode <= MENU;
               r_run  <= '0;
            end
         endcase
      end
   end

   assign mode      = r_mode;
   assign app_sel   = r_sel;
   assign app_run   = r_run;
   assign app_start = r_start;
endmodule

// File: tb/tb_app_state_controller.sv
// tb_app_state_controller: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_app_state_controller;
   localparam int N = 4;
   localparam int T = 5;
   localparam logic [3:0] OM = 4'b0101;
   localparam logic [3:0] AM = 4'b1110;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btnC = 1'b0, btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
   logic [3:0] app_ended = '0;
   logic [1:0] mode;
   logic [2:0] app_sel;
   logic [3:0] app_run;
   logic       app_start;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   int m_mode, m_sel, m_idle;
   bit m_start;

   always #5 clk = ~clk;

   app_state_controller #(
      .NUM_APPS(N), .IDX_W(3), .OVER_MASK(OM), .ABORT_MASK(AM), .IDLE_TIMEOUT(T)
   ) dut (
      .clk(clk), .reset(reset),
      .btnC(btnC), .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
      .app_ended(app_ended),
      .mode(mode), .app_sel(app_sel), .app_run(app_run), .app_start(app_start)
   );

   function automatic void m_reset();
      m_mode = 0; m_sel = 0; m_idle = 0; m_start = 1'b0;
   endfunction

   // Model: mode 0 menu, 1 run, 2 over; m_idle counts consecutive quiet cycles spent in OVER
   function automatic void m_step();
      bit any;
      any = btnC | btnL | btnR | btnU | btnD;
      m_start = 1'b0;
      if (m_mode == 0) begin
         if (btnC) begin m_mode = 1; m_start = 1'b1; end
         else m_sel = (m_sel + int'(btnR) - int'(btnL) + N) % N;
      end else if (m_mode == 1) begin
         if (app_ended[m_sel]) begin m_mode = OM[m_sel] ? 2 : 0; m_idle = 0; end
         else if (btnU && AM[m_sel]) m_mode = 0;
      end else begin
         m_idle = any ? 0 : m_idle + 1;
         if (btnC || m_idle == T) m_mode = 0;
      end
   endfunction

   function automatic logic [3:0] m_run();
      return (m_mode == 1) ? (4'b0001 << m_sel) : 4'b0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("mode", 32'(mode), 32'(m_mode));
         chk("app_sel", 32'(app_sel), 32'(m_sel));
         chk("app_run", 32'(app_run), 32'(m_run()));
         chk("app_start", 32'(app_start), 32'(m_start));
      end
   end

   task automatic cyc(input bit c, input bit l, input bit r, input bit u, input bit d, input logic [3:0] e);
      @(negedge clk);
      {btnC, btnL, btnR, btnU, btnD} = {c, l, r, u, d};
      app_ended = e;
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 4'b0000);
   endtask

   // Called just after an active edge: reset pulses between edges and must act at once
   task automatic async_rst();
      #1 reset = 1'b1;
      m_reset();
      #1;
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_run", 32'(app_run), 32'd0);
      chk("rst_sel", 32'(app_sel), 32'd0);
      chk("rst_start", 32'(app_start), 32'd0);
      #1 reset = 1'b0;
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("init_mode", 32'(mode), 32'd0);
      chk("init_sel", 32'(app_sel), 32'd0);
      chk("init_run", 32'(app_run), 32'd0);
      chk("init_start", 32'(app_start), 32'd0);

      // Cursor wrap
      cyc(0, 1, 0, 0, 0, 4'b0000);
      chk("wrap_left", 32'(app_sel), 32'd3);
      chk("model_wrap", 32'(m_sel), 32'd3);
      cyc(0, 0, 1, 0, 0, 4'b0000);
      cyc(0, 0, 1, 0, 0, 4'b0000);
      chk("wrap_right", 32'(app_sel), 32'd1);
      cyc(0, 1, 1, 0, 0, 4'b0000);
      chk("lr_nomove", 32'(app_sel), 32'd1);
      cyc(0, 0, 0, 1, 1, 4'b0000);
      chk("menu_ud_ignored", 32'(app_sel), 32'd1);

      // Launch and game-over page
      cyc(0, 0, 1, 0, 0, 4'b0000);
      cyc(1, 1, 0, 0, 0, 4'b0000);
      chk("launch_mode", 32'(mode), 32'd1);
      chk("launch_sel", 32'(app_sel), 32'd2);
      chk("launch_run", 32'(app_run), 32'h4);
      chk("launch_start", 32'(app_start), 32'd1);
      idle(1);
      chk("start_fall", 32'(app_start), 32'd0);
      cyc(0, 0, 0, 0, 0, 4'b0100);
      chk("over_mode", 32'(mode), 32'd2);
      chk("over_run", 32'(app_run), 32'd0);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      chk("over_exit", 32'(mode), 32'd0);
      chk("over_keep_sel", 32'(app_sel), 32'd2);

      // Direct return and ignored end bits
      cyc(0, 1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 0, 0, 4'b1101);
      chk("ignored_end", 32'(mode), 32'd1);
      cyc(0, 0, 0, 0, 0, 4'b0010);
      chk("direct_menu", 32'(mode), 32'd0);
      chk("direct_sel", 32'(app_sel), 32'd1);

      // Abort
      cyc(0, 1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 1, 0, 4'b0000);
      chk("abort_disabled", 32'(mode), 32'd1);
      cyc(0, 0, 0, 0, 0, 4'b0001);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      chk("run3", 32'(app_run), 32'h8);
      cyc(0, 0, 0, 1, 0, 4'b0000);
      chk("abort_menu", 32'(mode), 32'd0);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 1, 0, 4'b1000);
      chk("abort_end_mode", 32'(mode), 32'd0);
      chk("abort_end_run", 32'(app_run), 32'd0);

      // Idle timeout
      cyc(0, 0, 1, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 0, 0, 4'b0001);
      idle(4);
      chk("timeout_minus1", 32'(mode), 32'd2);
      idle(1);
      chk("timeout_exact", 32'(mode), 32'd0);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 0, 0, 4'b0001);
      idle(2);
      cyc(0, 1, 0, 0, 0, 4'b0000);
      chk("over_l_sel", 32'(app_sel), 32'd0);
      idle(4);
      chk("timeout_restart_minus1", 32'(mode), 32'd2);
      idle(1);
      chk("timeout_restart", 32'(mode), 32'd0);

      // Async reset mid-RUN
      cyc(0, 0, 1, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      async_rst();
      cyc(1, 0, 0, 0, 0, 4'b0000);
      chk("post_rst_mode", 32'(mode), 32'd1);
      chk("post_rst_run", 32'(app_run), 32'h1);
      chk("post_rst_start", 32'(app_start), 32'd1);

      // Randomized traffic, including occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
         if ($urandom_range(0, 399) == 0) async_rst();
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
